// File: rtl/cnn_sched_pkg.sv
// Shared types and constants for the CNN inference scheduler.
package cnn_sched_pkg;

  localparam int PIX_COUNT = 784;
  localparam int DIGIT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SNAP  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector: turns an asynchronous
// level into a registered one-cycle pulse in the Clk domain.
module pulse_sync_edge (
  input  logic Clk,
  input  logic reset_n,
  input  logic async_in,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic pulse_r;

  // synchronizer chain, edge history and registered pulse
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      sync1_r <= async_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      pulse_r <= sync2_r & ~prev_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/cnn_infer_scheduler.sv
// Frame-to-CNN inference scheduler: snapshots a frame, starts the CNN, waits
// for its result with a timeout. Optional result voting under INFER_VOTE_EN.
module cnn_infer_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int FRAME_SKIP     = 0,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int VOTE_N         = 3
) (
  input  logic               Clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic               frame_done,
  input  logic               cnn_valid,
  input  logic [DIGIT_W-1:0] cnn_digit,
  output logic               snap_en,
  output logic               cnn_start,
  output logic               busy,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               digit_valid,
  output logic               timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int SW = $clog2(FRAME_SKIP + 1) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SKIP_MAX   = SW'(FRAME_SKIP);

  sched_state_e       state_r, state_s;
  logic               frame_evt_s;
  logic [TW-1:0]      timer_r;
  logic [SW-1:0]      skip_r;
  logic [DIGIT_W-1:0] result_r;
  logic               snap_s, start_s, busy_s;
  logic               snap_en_r, cnn_start_r, busy_r;
  logic [DIGIT_W-1:0] digit_out_r;
  logic               digit_valid_r, timeout_err_r;
  logic               timeout_hit_s;

  pulse_sync_edge u_frame_sync (
    .Clk      (Clk),
    .reset_n  (reset_n),
    .async_in (frame_done),
    .pulse    (frame_evt_s)
  );

  // cnn_valid wins over a timeout landing in the same cycle
  assign timeout_hit_s = (state_r == ST_WAIT) && !cnn_valid && (timer_r == TIMER_LAST);

  // state register
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_evt_s && run && (skip_r == SKIP_MAX)) state_s = ST_SNAP;
        else                                            state_s = ST_IDLE;
      end
      ST_SNAP:  state_s = ST_START;
      ST_START: state_s = ST_WAIT;
      ST_WAIT: begin
        if (cnn_valid)                 state_s = ST_DONE;
        else if (timer_r == TIMER_LAST) state_s = ST_IDLE;
        else                            state_s = ST_WAIT;
      end
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // output decode from the next state so registered outputs align with the state
  always_comb begin
    snap_s  = 1'b0;
    start_s = 1'b0;
    busy_s  = 1'b0;
    case (state_s)
      ST_SNAP:  begin snap_s  = 1'b1; busy_s = 1'b1; end
      ST_START: begin start_s = 1'b1; busy_s = 1'b1; end
      ST_WAIT:  busy_s = 1'b1;
      default:  busy_s = 1'b0;
    endcase
  end

  // output registers
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_en_r   <= 1'b0;
      cnn_start_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      snap_en_r   <= snap_s;
      cnn_start_r <= start_s;
      busy_r      <= busy_s;
    end
  end

  // wait timer, frame skip counter, captured result and sticky timeout
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_r       <= '0;
      skip_r        <= '0;
      result_r      <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      if (state_r == ST_START)     timer_r <= '0;
      else if (state_r == ST_WAIT) timer_r <= timer_r + TW'(1);
      else                         timer_r <= timer_r;

      if (state_r == ST_DONE)
        skip_r <= '0;
      else if ((state_r == ST_IDLE) && frame_evt_s && (state_s == ST_IDLE) && (skip_r != SKIP_MAX))
        skip_r <= skip_r + SW'(1);
      else
        skip_r <= skip_r;

      if ((state_r == ST_WAIT) && cnn_valid) result_r <= cnn_digit;
      else                                   result_r <= result_r;

      timeout_err_r <= timeout_err_r | timeout_hit_s;
    end
  end

`ifdef INFER_VOTE_EN
  localparam int VW = $clog2(VOTE_N + 1);
  localparam logic [VW-1:0] VOTE_MAX = VW'(VOTE_N);

  logic [DIGIT_W-1:0] cand_r;
  logic [VW-1:0]      vote_r, vote_s;

  // vote count after the result now in DONE
  always_comb begin
    vote_s = vote_r;
    if (result_r == cand_r) begin
      if (vote_r == VOTE_MAX) vote_s = vote_r;
      else                    vote_s = vote_r + VW'(1);
    end else begin
      vote_s = VW'(1);
    end
  end

  // candidate tracking and voted display update
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_r        <= '0;
      vote_r        <= '0;
      digit_out_r   <= '0;
      digit_valid_r <= 1'b0;
    end else if (state_r == ST_DONE) begin
      cand_r <= result_r;
      vote_r <= vote_s;
      if (vote_s == VOTE_MAX) begin
        digit_out_r   <= result_r;
        digit_valid_r <= 1'b1;
      end
    end
  end
`else
  // display update on every accepted result
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_out_r   <= '0;
      digit_valid_r <= 1'b0;
    end else if (state_r == ST_DONE) begin
      digit_out_r   <= result_r;
      digit_valid_r <= 1'b1;
    end
  end
`endif

  assign snap_en     = snap_en_r;
  assign cnn_start   = cnn_start_r;
  assign busy        = busy_r;
  assign digit_out   = digit_out_r;
  assign digit_valid = digit_valid_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_cnn_infer_scheduler.sv
// Self-checking bench for cnn_infer_scheduler against a transaction-level model.
module tb_cnn_infer_scheduler;

  localparam int FS = 2;
  localparam int T  = 16;
  localparam int VN = 3;

  logic       Clk = 1'b0;
  logic       reset_n, run, frame_done, cnn_valid;
  logic [3:0] cnn_digit;
  logic       snap_en, cnn_start, busy, digit_valid, timeout_err;
  logic [3:0] digit_out;

  int total = 0;
  int bad   = 0;
  int snap_seen = 0;

  // model of the observable scheduler state
  int         m_skip;
  int         m_snaps;
  logic [3:0] m_digit;
  logic       m_dvalid;
  logic       m_terr;
  logic [3:0] m_cand;
  int         m_votes;

  cnn_infer_scheduler #(.FRAME_SKIP(FS), .TIMEOUT_CYCLES(T), .VOTE_N(VN)) dut (
    .Clk(Clk), .reset_n(reset_n), .run(run), .frame_done(frame_done),
    .cnn_valid(cnn_valid), .cnn_digit(cnn_digit), .snap_en(snap_en),
    .cnn_start(cnn_start), .busy(busy), .digit_out(digit_out),
    .digit_valid(digit_valid), .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (snap_en === 1'b1) snap_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_skip = 0; m_digit = 4'd0; m_dvalid = 1'b0; m_terr = 1'b0;
    m_cand = 4'd0; m_votes = 0;
  endtask

  task automatic m_accept(input logic [3:0] d);
`ifdef INFER_VOTE_EN
    if (d == m_cand) begin
      if (m_votes < VN) m_votes++;
    end else begin
      m_cand = d; m_votes = 1;
    end
    if (m_votes == VN) begin m_digit = d; m_dvalid = 1'b1; end
`else
    m_digit = d; m_dvalid = 1'b1;
`endif
    m_skip = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_digit"}, digit_out, m_digit);
    chk({tag, "_dvalid"}, digit_valid, m_dvalid);
    chk({tag, "_terr"}, timeout_err, m_terr);
  endtask

  task automatic pulse_frame();
    @(posedge Clk); #1 frame_done = 1'b1;
    @(posedge Clk); #1 frame_done = 1'b0;
  endtask

  // one frame event; if accepted, cnn_valid comes lat cycles after cnn_start (lat > T: none)
  task automatic do_frame(input logic run_v, input int lat, input logic [3:0] dig,
                          input logic drop_run, input logic wait_frame);
    logic acc, found;
    int   n, lim;
    run = run_v;
    acc = run_v && (m_skip == FS);
    if (!acc && m_skip < FS) m_skip++;
    if (acc) m_snaps++;
    pulse_frame();
    found = 1'b0; n = 0;
    while (n < 8 && !found) begin
      @(negedge Clk); n++;
      if (snap_en === 1'b1) found = 1'b1;
    end
    chk("snap_accept", found, acc);
    if (acc && found) begin
      @(negedge Clk);
      chk("start_after_snap", cnn_start, 1'b1);
      chk("snap_one_cycle", snap_en, 1'b0);
      chk("busy_in_start", busy, 1'b1);
      if (drop_run) run = 1'b0;
      lim = (lat < T) ? lat : T;
      for (int k = 1; k <= T + 1; k++) begin
        @(posedge Clk); #1;
        frame_done = wait_frame && (k == 1);
        if (k == lat) begin cnn_valid = 1'b1; cnn_digit = dig; end
        else begin cnn_valid = 1'b0; cnn_digit = 4'($urandom); end
        @(negedge Clk);
        chk("busy_window", busy, (k <= lim));
        chk("no_restart", {snap_en, cnn_start}, 2'b00);
        if (k == T) chk("terr_before_timeout", timeout_err, m_terr);
      end
      cnn_valid = 1'b0;
      if (lat <= T) m_accept(dig);
      else m_terr = 1'b1;
      repeat (2) @(negedge Clk);
      check_idle_outputs("after_frame");
    end else if (found) begin
      repeat (T + 6) @(negedge Clk);
    end else begin
      check_idle_outputs("skipped_frame");
    end
  endtask

  task automatic accept_frame(input int lat, input logic [3:0] dig);
    while (m_skip != FS) do_frame(1'b1, 0, 4'd0, 1'b0, 1'b0);
    do_frame(1'b1, lat, dig, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; frame_done = 1'b0; cnn_valid = 1'b0; cnn_digit = 4'd0;
    m_reset(); m_snaps = 0;
    repeat (3) @(negedge Clk);
    chk("reset_outputs", {snap_en, cnn_start, busy, digit_out, digit_valid, timeout_err}, 9'd0);
    @(posedge Clk); #1 reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    chk("post_reset_outputs", {snap_en, cnn_start, busy, digit_out, digit_valid, timeout_err}, 9'd0);

    // stray result while idle
    @(posedge Clk); #1 cnn_valid = 1'b1; cnn_digit = 4'd3;
    @(posedge Clk); #1 cnn_valid = 1'b0;
    repeat (3) @(negedge Clk);
    check_idle_outputs("stray_idle");

    // six edges with FRAME_SKIP=2: snaps on edges 3 and 6
    for (int e = 1; e <= 6; e++) do_frame(1'b1, 3, 4'd7, 1'b0, 1'b0);
    chk("six_edge_snaps", snap_seen, 2);

    // timeout, then cnn_valid exactly on the timeout cycle
    accept_frame(T + 4, 4'd0);
    accept_frame(T, 4'd6);

    // frame edge during WAIT is ignored
    accept_frame(12, 4'd2);
    do_frame(1'b1, 10, 4'd8, 1'b0, 1'b1);
    do_frame(1'b1, 10, 4'd8, 1'b1, 1'b1);

    // voting sequence
    accept_frame(2, 4'd4);
    accept_frame(2, 4'd4);
    accept_frame(2, 4'd5);
    accept_frame(2, 4'd5);
    accept_frame(2, 4'd5);

    // randomized frames
    for (int i = 0; i < 40; i++) begin
      int lat_r;
      lat_r = $urandom_range(1, T + 3);
      do_frame($urandom_range(0, 3) != 0, lat_r, 4'($urandom), $urandom_range(0, 1) == 1,
               (lat_r >= 8) && ($urandom_range(0, 1) == 1));
    end

    // reset in the middle of WAIT, then a late cnn_valid
    run = 1'b1;
    while (m_skip != FS) do_frame(1'b1, 0, 4'd0, 1'b0, 1'b0);
    pulse_frame();
    m_snaps++;
    repeat (8) @(posedge Clk);
    #1 reset_n = 1'b0;
    @(negedge Clk);
    chk("midwait_reset_outputs", {snap_en, cnn_start, busy, digit_out, digit_valid, timeout_err}, 9'd0);
    @(posedge Clk); #1 reset_n = 1'b1;
    m_reset();
    @(posedge Clk); #1 cnn_valid = 1'b1; cnn_digit = 4'd9;
    @(posedge Clk); #1 cnn_valid = 1'b0;
    repeat (3) @(negedge Clk);
    chk("late_valid_ignored", {snap_en, cnn_start, busy, digit_out, digit_valid, timeout_err}, 9'd0);

    for (int i = 0; i < 6; i++) do_frame(1'b1, $urandom_range(1, T + 2), 4'($urandom), 1'b0, 1'b0);
    chk("total_snaps", snap_seen, m_snaps);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
